fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised successor fetch stage: PC generator plus prefetch queue decoupling instruction memory from decode.
//  Issues one pipelined read per cycle to a 1-cycle-latency instruction memory and buffers {pc, instruction} pairs.
//  Presents them downstream via valid/ready. Branch redirect flushes the queue and restarts fetch at the target.
//  Sits between the PC/branch logic of execute and the decode stage.
// PARAMETERS
//  WORD       64  PC/address width in bits
//  INSTR_LEN  32  instruction width in bits
//  DEPTH      4   queue entries; power of two, >=2; >=3 needed for 1 instr/cycle sustained
//  RESET_PC   0   PC value loaded on reset
//  PC_STEP    4   PC increment per issued fetch
// PORTS
//  clk              in   1          system clock, rising edge
//  reset            in   1          asynchronous, active-high reset
//  redirect_valid   in   1          branch taken this cycle; flush and restart
//  redirect_target  in   WORD       new fetch PC when redirect_valid
//  imem_req         out  1          read request this cycle
//  imem_addr        out  WORD       read address (= current PC)
//  imem_rdata       in   INSTR_LEN  read data, valid the cycle after imem_req
//  out_valid        out  1          queue head valid
//  out_ready        in   1          decode accepts head
//  out_instruction  out  INSTR_LEN  head instruction
//  out_pc           out  WORD       head instruction address
//  occupancy        out  log2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-fetch): pc=RESET_PC, queue empty, inflight=0.
//   Outputs: out_valid=0, imem_req=0, occupancy=0; out_instruction/out_pc=0.
//  State: pc, inflight (1b, request issued last cycle), req_pc (address of inflight request), queue.
//  Issue: imem_req = !redirect_valid && (occupancy + inflight < DEPTH); imem_addr = pc.
//   On issue: pc <= pc + PC_STEP (mod 2^WORD, wraps silently); req_pc <= pc; inflight <= 1.
//   With no issue, inflight <= 0.
//   Issue rule never credits a same-cycle pop, so responses can never overflow the queue.
//  Response: when inflight && !redirect_valid, push {req_pc, imem_rdata} at cycle end.
//  Latency: request at cycle t, data on imem_rdata at t+1, out_valid at t+2 (no bypass).
//  Pop: out_valid && out_ready removes head. Push and pop in the same cycle keep occupancy.
//  out_valid = (occupancy != 0); out_* driven from the head entry. Values are don't-care when empty, held stable while !out_ready.
//  Redirect (cycle t): imem_req=0 in t.
//   Any response arriving in t is discarded.
//   Queue flushed at end of t (occupancy=0 at t+1).
//   pc <= redirect_target; inflight <= 0; first request for target issued at t+1.
//   A head handshake in t completes normally (decode consumed it); the queue is still flushed.
//  Redirect while empty/idle: same rules. Back-to-back redirects: last one wins.
//  Full queue: imem_req held 0 and pc holds until a pop frees a slot.
//  out_ready low indefinitely: queue fills to DEPTH, fetch stalls, no entry lost or duplicated.
// STRUCTURE
//  constants.vh: WORD, INSTR_LEN (existing); no new typedefs.
//  Sub-module sync_fifo #(WIDTH=WORD+INSTR_LEN, DEPTH): async reset, synchronous flush.
//   Push/pop/full/empty/count; reusable elsewhere.
//  Top level holds the pc/inflight/req_pc registers, issue logic and redirect handling.
// TESTING
//  Reset then out_ready=1, memory returns addr-derived data.
//   -> imem_addr 0,4,8,... one per cycle; first out_valid at cycle 2; out_pc 0,4,8 in order.
//  out_ready=0 from reset, DEPTH=4.
//   -> exactly 4 requests (addr 0..12); occupancy=4; imem_req stays 0.
//   Then out_ready=1 -> pops 0,4,8,12, fetch resumes at 16.
//  Redirect to 0x100 while 3 queued and one in flight.
//   -> next cycle occupancy=0, out_valid=0; imem_addr=0x100; first out_pc=0x100; no stale PCs ever emitted.
//  Redirect in the same cycle as a head pop, then a second redirect the next cycle to 0x200.
//   -> only 0x200 stream appears.
//  RESET_PC=2^WORD-8, free run.
//   -> out_pc sequence ...F8, ...FC, 0, 4 (wrap).
//  Assert reset for 1 cycle mid-stream, asynchronous to clk edge.
//   -> outputs clear immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared defaults and helpers for the fetch/prefetch slice.
package fetch_prefetch_unit_pkg;

    localparam int unsigned WORD_DEF      = 64;
    localparam int unsigned INSTR_LEN_DEF = 32;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned PC_STEP_DEF   = 4;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch stage.
interface fetch_prefetch_unit_if
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WORD      = WORD_DEF,
    parameter int unsigned INSTR_LEN = INSTR_LEN_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
);
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic                 redirect_valid;
    logic [WORD-1:0]      redirect_target;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_LEN-1:0] out_instruction;
    logic [WORD-1:0]      out_pc;
    logic [OCC_W-1:0]     occupancy;

    // The fetch unit side.
    modport master (
        input  redirect_valid, redirect_target, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instruction, out_pc, occupancy
    );

    // Execute / memory / decode side.
    modport slave (
        output redirect_valid, redirect_target, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instruction, out_pc, occupancy
    );

endinterface

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with async reset and synchronous flush; DEPTH must be a power of two.
module fetch_prefetch_unit_sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; it is only read when count says the slot is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// PC generator plus prefetch queue between a 1-cycle instruction memory and decode.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned     WORD      = WORD_DEF,
    parameter int unsigned     INSTR_LEN = INSTR_LEN_DEF,
    parameter int unsigned     DEPTH     = DEPTH_DEF,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter int unsigned     PC_STEP   = PC_STEP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned OCC_W   = occ_width(DEPTH);
    localparam int unsigned ENTRY_W = WORD + INSTR_LEN;

    logic [WORD-1:0]    pc;
    logic [WORD-1:0]    req_pc;
    logic               inflight;
    logic               issue;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OCC_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    // An outstanding response already owns a slot; a same-cycle pop is deliberately not
    // credited so the returning data can never find the queue full.
    assign issue = !reset && !bus.redirect_valid && !fifo_full &&
                   (({1'b0, count} + (OCC_W+1)'(inflight)) < (OCC_W+1)'(DEPTH));
    assign push  = inflight && !bus.redirect_valid;
    assign pop   = !fifo_empty && bus.out_ready;

    assign bus.imem_req        = issue;
    assign bus.imem_addr       = pc;
    assign bus.out_valid       = !fifo_empty;
    assign bus.occupancy       = count;
    assign bus.out_pc          = fifo_empty ? '0 : head[ENTRY_W-1:INSTR_LEN];
    assign bus.out_instruction = fifo_empty ? '0 : head[INSTR_LEN-1:0];

    // PC advances per issued fetch; a redirect drops the outstanding request and retargets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + WORD'(PC_STEP);
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_prefetch_unit_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (push),
        .wdata ({req_pc, bus.imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised and directed bench for fetch_prefetch_unit against a queue-level reference model.
module tb_fetch_prefetch_unit;

    localparam int WORD    = 64;
    localparam int ILEN    = 32;
    localparam int DEPTH   = 4;
    localparam int PC_STEP = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int fails   = 0;

    fetch_prefetch_unit_if #(.WORD(WORD), .INSTR_LEN(ILEN), .DEPTH(DEPTH)) bus ();
    fetch_prefetch_unit_if #(.WORD(WORD), .INSTR_LEN(ILEN), .DEPTH(DEPTH)) bus2 ();

    fetch_prefetch_unit #(
        .WORD(WORD), .INSTR_LEN(ILEN), .DEPTH(DEPTH), .RESET_PC(64'h0), .PC_STEP(PC_STEP)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus.master)
    );

    fetch_prefetch_unit #(
        .WORD(WORD), .INSTR_LEN(ILEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC), .PC_STEP(PC_STEP)
    ) dut_wrap (
        .clk(clk), .reset(rst), .bus(bus2.master)
    );

    always #5 clk = ~clk;

    // reference model state
    ent_t        m_q[$];
    logic [63:0] m_pc;
    bit          m_pend;
    logic [63:0] m_pend_pc;

    // observations from the last cycle
    bit          obs_req;
    logic [63:0] obs_addr;
    bit          obs_valid;
    logic [63:0] obs_pc;
    logic [2:0]  obs_occ;

    logic [63:0] w_pcs[$];
    logic [31:0] w_ins[$];

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_instr", 64'(bus.out_instruction), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_q.delete();
        m_pc   = 64'h0;
        m_pend = 1'b0;
    endtask

    // one clock: drive inputs, compare at the falling edge, then answer memory and step the model
    task automatic cycle(input bit rdy, input bit rv, input logic [63:0] tgt);
        bit   exp_req;
        ent_t tmp;
        bus.out_ready       = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        @(negedge clk);
        #1;
        exp_req   = !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
        obs_req   = bus.imem_req;
        obs_addr  = bus.imem_addr;
        obs_valid = bus.out_valid;
        obs_pc    = bus.out_pc;
        obs_occ   = bus.occupancy;
        chk("imem_req", 64'(obs_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", obs_addr, m_pc);
        chk("out_valid", 64'(obs_valid), 64'(m_q.size() != 0));
        chk("occupancy", 64'(obs_occ), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("out_pc", obs_pc, m_q[0].pc);
            chk("out_instruction", 64'(bus.out_instruction), 64'(m_q[0].ins));
        end
        if (bus2.out_valid) begin
            w_pcs.push_back(bus2.out_pc);
            w_ins.push_back(bus2.out_instruction);
        end
        @(posedge clk);
        #1;
        bus.imem_rdata = obs_req ? mem_data(obs_addr) : $urandom;
        if (rv) begin
            m_q.delete();
            m_pc   = tgt;
            m_pend = 1'b0;
        end else begin
            if (rdy && m_q.size() != 0) tmp = m_q.pop_front();
            if (m_pend) begin
                tmp.pc  = m_pend_pc;
                tmp.ins = mem_data(m_pend_pc);
                m_q.push_back(tmp);
            end
            if (exp_req) begin
                m_pend    = 1'b1;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 64'(PC_STEP);
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    // memory for the wrap instance: always ready, decode always accepts
    initial begin
        bit          r;
        logic [63:0] a;
        bus2.out_ready       = 1'b1;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_target = '0;
        bus2.imem_rdata      = '0;
        forever begin
            @(negedge clk);
            r = bus2.imem_req;
            a = bus2.imem_addr;
            @(posedge clk);
            #1;
            bus2.imem_rdata = r ? mem_data(a) : $urandom;
        end
    end

    initial begin
        int          n;
        int          bias;
        logic [63:0] pops[$];
        logic [63:0] first_req;
        bit          got_req;
        bit          seen;
        logic [63:0] tgt;

        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_rdata      = '0;

        // free run with addr-derived data
        reset_dut();
        cycle(1, 0, 0);
        chk("a_c0_req", 64'(obs_req), 64'd1);
        chk("a_c0_addr", obs_addr, 64'h0);
        cycle(1, 0, 0);
        chk("a_c1_addr", obs_addr, 64'h4);
        chk("a_c1_valid", 64'(obs_valid), 64'd0);
        cycle(1, 0, 0);
        chk("a_c2_valid", 64'(obs_valid), 64'd1);
        chk("a_c2_pc", obs_pc, 64'h0);
        cycle(1, 0, 0);
        chk("a_c3_pc", obs_pc, 64'h4);
        chk("a_c3_addr", obs_addr, 64'hC);

        // decode stalled from reset: queue fills, fetch stops
        reset_dut();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0);
            if (obs_req) n++;
        end
        chk("b_req_count", 64'(n), 64'd4);
        chk("b_occ_full", 64'(obs_occ), 64'd4);
        chk("b_req_stalled", 64'(obs_req), 64'd0);
        pops.delete();
        got_req = 1'b0;
        first_req = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            if (obs_valid) pops.push_back(obs_pc);
            if (obs_req && !got_req) begin
                got_req   = 1'b1;
                first_req = obs_addr;
            end
        end
        chk("b_pop_count", 64'(pops.size() >= 4), 64'd1);
        if (pops.size() >= 4) begin
            chk("b_pop0", pops[0], 64'h0);
            chk("b_pop1", pops[1], 64'h4);
            chk("b_pop2", pops[2], 64'h8);
            chk("b_pop3", pops[3], 64'hC);
        end
        chk("b_resume_addr", first_req, 64'h10);

        // redirect with three queued and one in flight
        reset_dut();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        cycle(0, 1, 64'h100);
        chk("c_occ_before", 64'(obs_occ), 64'd3);
        chk("c_req_in_redirect", 64'(obs_req), 64'd0);
        cycle(0, 0, 0);
        chk("c_occ_after", 64'(obs_occ), 64'd0);
        chk("c_valid_after", 64'(obs_valid), 64'd0);
        chk("c_req_after", 64'(obs_req), 64'd1);
        chk("c_addr_after", obs_addr, 64'h100);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle(1, 0, 0);
            if (obs_valid) begin
                seen = 1'b1;
                chk("c_first_pc", obs_pc, 64'h100);
            end
        end
        chk("c_first_seen", 64'(seen), 64'd1);

        // redirect coinciding with a pop, then a second redirect
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        cycle(1, 1, 64'h180);
        chk("d_pop_in_redirect", 64'(obs_valid), 64'd1);
        cycle(1, 1, 64'h200);
        chk("d_valid_between", 64'(obs_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle(1, 0, 0);
            if (obs_valid) begin
                seen = 1'b1;
                chk("d_first_pc", obs_pc, 64'h200);
            end
        end
        chk("d_first_seen", 64'(seen), 64'd1);

        // randomised traffic with sporadic async resets
        bias = 7;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 64) == 0) bias = $urandom_range(1, 10);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) < bias, $urandom_range(0, 19) == 0, tgt);
            if ($urandom_range(0, 299) == 0) reset_dut();
        end

        // wrap-around instance
        reset_dut();
        w_pcs.delete();
        w_ins.delete();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        chk("f_wrap_count", 64'(w_pcs.size() >= 4), 64'd1);
        if (w_pcs.size() >= 4) begin
            chk("f_wrap0", w_pcs[0], 64'hFFFF_FFFF_FFFF_FFF8);
            chk("f_wrap1", w_pcs[1], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("f_wrap2", w_pcs[2], 64'h0);
            chk("f_wrap3", w_pcs[3], 64'h4);
            chk("f_wrap_ins2", 64'(w_ins[2]), 64'(32'h5EED_1234));
            chk("f_wrap_ins0", 64'(w_ins[0]), 64'(mem_data(64'hFFFF_FFFF_FFFF_FFF8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
